// File: rtl/boron_pkg.sv
// boron_pkg: Boron tables, key-schedule step and its inverse, shared by cipher and decipher.
package boron_pkg;
  localparam int CTR_W = 5;
  localparam logic [3:0] SBOX [16] = '{4'hE, 4'h4, 4'hB, 4'h1, 4'h7, 4'h9, 4'hC, 4'hA,
                                       4'hD, 4'h2, 4'h0, 4'hF, 4'h8, 4'h5, 4'h3, 4'h6};
  localparam logic [3:0] INV_SBOX [16] = '{4'hA, 4'h3, 4'h9, 4'hE, 4'h1, 4'hD, 4'hF, 4'h4,
                                           4'hC, 4'h5, 4'h7, 4'h2, 4'h6, 4'h8, 4'h0, 4'hB};
  localparam int ROT [4] = '{0, 1, 7, 9};
  // Block shuffle: output nibble j takes input nibble SHUF[j].
  localparam logic [3:0] SHUF [16] = '{4'd3, 4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6,
                                       4'd11, 4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14};
  typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} state_e;
  function automatic logic [15:0] rotr16(input logic [15:0] x, input int n);
    return (x >> n) | (x << (16 - n));
  endfunction
  function automatic logic [79:0] ks(input logic [79:0] k, input logic [CTR_W-1:0] i);
    logic [79:0] r;
    r = {k[66:0], k[79:67]};
    r[3:0] = SBOX[r[3:0]];
    r[63:59] = r[63:59] ^ i;
    return r;
  endfunction
  function automatic logic [79:0] inv_ks(input logic [79:0] k, input logic [CTR_W-1:0] i);
    logic [79:0] r;
    r = k;
    r[63:59] = r[63:59] ^ i;
    r[3:0] = INV_SBOX[r[3:0]];
    return {r[12:0], r[79:13]};
  endfunction
endpackage

// File: rtl/boron_inv_round.sv
// boron_inv_round: combinational inverse of one Boron round (xor, rotations, shuffle, S-box undone in reverse).
module boron_inv_round
  import boron_pkg::*;
(
  input  logic [63:0] data_i,
  output logic [63:0] data_o
);
  logic [15:0] w [4];
  logic [63:0] unrot;
  logic [63:0] unshuf;
  always_comb begin
    for (int j = 0; j < 4; j++) w[j] = data_i[16*j +: 16];
    // Forward xor layer is w1^=w0, w3^=w2, w0^=w3, w2^=w1; undo in reverse order.
    w[2] = w[2] ^ w[1];
    w[0] = w[0] ^ w[3];
    w[3] = w[3] ^ w[2];
    w[1] = w[1] ^ w[0];
    unrot = '0;
    for (int j = 0; j < 4; j++) unrot[16*j +: 16] = rotr16(w[j], ROT[j]);
    unshuf = '0;
    for (int j = 0; j < 16; j++) unshuf[4*SHUF[j] +: 4] = unrot[4*j +: 4];
    data_o = '0;
    for (int j = 0; j < 16; j++) data_o[4*j +: 4] = INV_SBOX[unshuf[4*j +: 4]];
  end
endmodule

// File: rtl/boron_dec_core.sv
// boron_dec_core: iterative Boron decryptor; expands the key schedule to K_R, then one inverse round per clock.
module boron_dec_core
  import boron_pkg::*;
#(
  parameter int Key_Bit_Size     = 80,
  parameter int Number_of_Rounds = 26
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [Key_Bit_Size-1:0] Key,
  input  logic [63:0]             Cipher_Text,
  output logic [63:0]             Plain_Text,
  output logic                    busy,
  output logic                    done
);
  if (Key_Bit_Size != 80) begin : g_bad_key
    $error("boron_dec_core supports only an 80-bit key");
  end
  localparam logic [CTR_W-1:0] LAST = CTR_W'(Number_of_Rounds - 1);
  state_e           state_q, state_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic [79:0]      key_q, key_d, key_fwd, key_inv;
  logic [63:0]      text_q, text_d, plain_q, plain_d, inv_out;
  assign key_fwd    = ks(key_q, ctr_q);
  assign key_inv    = inv_ks(key_q, ctr_q);
  assign busy       = (state_q == EXPAND) || (state_q == DECRYPT);
  assign done       = state_q == DONE;
  assign Plain_Text = plain_q;
  boron_inv_round u_inv_round (.data_i(text_q), .data_o(inv_out));
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    key_d   = key_q;
    text_d  = text_q;
    plain_d = plain_q;
    case (state_q)
      IDLE: if (start) begin
        key_d   = Key;
        text_d  = Cipher_Text;
        ctr_d   = CTR_W'(1);
        state_d = EXPAND;
      end
      EXPAND: begin
        key_d = key_fwd;
        if (ctr_q == LAST) begin
          text_d  = text_q ^ key_fwd[63:0];
          state_d = DECRYPT;
        end else ctr_d = ctr_q + 1'b1;
      end
      DECRYPT: begin
        key_d  = key_inv;
        text_d = inv_out ^ key_inv[63:0];
        ctr_d  = ctr_q - 1'b1;
        if (ctr_q == CTR_W'(1)) begin
          state_d = DONE;
          plain_d = inv_out ^ key_inv[63:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ctr_q   <= '0;
      key_q   <= '0;
      text_q  <= '0;
      plain_q <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      key_q   <= key_d;
      text_q  <= text_d;
      plain_q <= plain_d;
    end
  end
endmodule

// File: tb/tb_boron_dec_core.sv
// tb_boron_dec_core: encrypts with an independent Boron model, then checks the core recovers the plaintext.
module tb_boron_dec_core;
  import boron_pkg::*;
  localparam int R = 26;
  localparam logic [63:0] SB_TAB = 64'h6358_F02D_AC97_1B4E;
  logic        clk = 0;
  logic        reset = 0;
  logic        start = 0;
  logic [79:0] Key = '0;
  logic [63:0] Cipher_Text = '0;
  logic [63:0] Plain_Text;
  logic        busy, done;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  boron_dec_core #(.Key_Bit_Size(80), .Number_of_Rounds(R)) dut (
    .clk(clk), .reset(reset), .start(start), .Key(Key),
    .Cipher_Text(Cipher_Text), .Plain_Text(Plain_Text), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [3:0] m_sb(input logic [3:0] v);
    logic [63:0] t;
    t = SB_TAB;
    return t[4*v +: 4];
  endfunction
  function automatic logic [63:0] m_round(input logic [63:0] x);
    logic [63:0] s, y;
    logic [15:0] w [4];
    int amt [4];
    amt = '{0, 1, 7, 9};
    for (int j = 0; j < 16; j++) s[4*j +: 4] = m_sb(x[4*j +: 4]);
    for (int j = 0; j < 16; j++) y[4*j +: 4] = s[4*((5*j + 3) % 16) +: 4];
    for (int j = 0; j < 4; j++) begin
      w[j] = y[16*j +: 16];
      w[j] = (w[j] << amt[j]) | (w[j] >> (16 - amt[j]));
    end
    w[1] ^= w[0];
    w[3] ^= w[2];
    w[0] ^= w[3];
    w[2] ^= w[1];
    return {w[3], w[2], w[1], w[0]};
  endfunction
  function automatic logic [79:0] m_ks(input logic [79:0] k, input int i);
    logic [79:0] r;
    logic [4:0]  c;
    c = 5'(i);
    r = {k[66:0], k[79:67]};
    r[3:0] = m_sb(r[3:0]);
    r[63:59] ^= c;
    return r;
  endfunction
  function automatic logic [63:0] m_enc(input logic [79:0] k, input logic [63:0] p);
    logic [63:0] s;
    s = p;
    for (int i = 1; i < R; i++) begin
      s = m_round(s ^ k[63:0]);
      k = m_ks(k, i);
    end
    return s ^ k[63:0];
  endfunction
  // One decryption; optionally pokes start/Key/Cipher_Text mid-run to prove they are ignored.
  task automatic do_op(input logic [79:0] k, input logic [63:0] c, input logic [63:0] hold,
                       input int glitch, output logic [63:0] pt, output int lat);
    int busy_bad, hold_bad;
    busy_bad = 0;
    hold_bad = 0;
    @(negedge clk);
    chk("done_pulse", done, 0);
    start = 1;
    Key = k;
    Cipher_Text = c;
    @(negedge clk);
    start = 0;
    lat = 1;
    while (!done && lat < 200) begin
      if (!busy) busy_bad++;
      if (Plain_Text !== hold) hold_bad++;
      if (lat == glitch) begin
        start = 1;
        Key = {$urandom, $urandom, $urandom};
        Cipher_Text = {$urandom, $urandom};
      end else start = 0;
      @(negedge clk);
      lat++;
    end
    start = 0;
    if (busy) busy_bad++;
    chk("busy", busy_bad, 0);
    chk("hold", hold_bad, 0);
    pt = Plain_Text;
  endtask
  initial begin
    logic [63:0] pt, p, prev;
    logic [79:0] k, kk;
    int lat, ii;
    #12;
    chk("rst_pt", Plain_Text, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1;
    do_op('0, m_enc('0, '0), '0, -1, pt, lat);
    chk("rt_zero", pt, 0);
    chk("latency", lat, 51);
    prev = pt;
    k = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    p = 64'h0123_4567_89AB_CDEF;
    do_op(k, m_enc(k, p), prev, -1, pt, lat);
    chk("rt_ones", pt, p);
    chk("latency2", lat, 51);
    prev = pt;
    do_op(k, m_enc(k, p), prev, 20, pt, lat);
    chk("ignore_start", pt, p);
    chk("latency3", lat, 51);
    @(negedge clk);
    start = 1;
    Key = '0;
    Cipher_Text = m_enc('0, '0);
    @(negedge clk);
    start = 0;
    repeat (29) @(negedge clk);
    reset = 0;
    #1;
    chk("abort_pt", Plain_Text, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1;
    do_op(k, m_enc(k, p), '0, -1, pt, lat);
    chk("after_abort", pt, p);
    prev = pt;
    for (int n = 0; n < 100; n++) begin
      k = {$urandom, $urandom, $urandom};
      p = {$urandom, $urandom};
      do_op(k, m_enc(k, p), prev, -1, pt, lat);
      chk("b2b", pt, p);
      chk("b2b_lat", lat, 51);
      prev = pt;
    end
    for (int n = 0; n < 1000; n++) begin
      kk = {$urandom, $urandom, $urandom};
      ii = 1 + (n % 25);
      chk("ks_model", ks(kk, CTR_W'(ii)), m_ks(kk, ii));
      chk("inv_ks", inv_ks(ks(kk, CTR_W'(ii)), CTR_W'(ii)), kk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
